// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of a word-only data memory. Takes byte/half/word
// load and store requests over valid/ready, sequences the memory strobes, performs
// read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
module load_store_unit #(
    parameter int unsigned MEMWIDTH = 32,
    parameter int unsigned ADDSIZE  = 6
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [1:0]           ReqSize,
    input  logic                 ReqUnsigned,
    input  logic [ADDSIZE+1:0]   ReqAddr,
    input  logic [MEMWIDTH-1:0]  ReqWData,
    output logic                 RspValid,
    output logic [MEMWIDTH-1:0]  RspData,
    output logic                 RspError,
    output logic [ADDSIZE-1:0]   MemAddress,
    output logic [MEMWIDTH-1:0]  MemWriteData,
    output logic                 MemoryRead,
    output logic                 MemoryWrite,
    input  logic [MEMWIDTH-1:0]  MemReadData
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        DATA  = 2'b10,
        WRITE = 2'b11
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  accept_s;
    logic                  misaligned_s;
    logic                  word_store_s;
    logic                  req_write_r;
    logic [1:0]            req_size_r;
    logic                  req_unsigned_r;
    logic [1:0]            req_lane_r;
    logic [MEMWIDTH-1:0]   req_wdata_r;
    logic                  rsp_valid_r;
    logic [MEMWIDTH-1:0]   rsp_data_r;
    logic                  rsp_error_r;
    logic [ADDSIZE-1:0]    mem_address_r;
    logic [MEMWIDTH-1:0]   mem_write_data_r;

    // Halfwords must sit on even addresses, words (and size 11) on multiples of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lane[0];
            default: is_misaligned = (lane != 2'b00);
        endcase
    endfunction

    // Pick the addressed lane out of a little-endian word and extend it to full width.
    function automatic logic [MEMWIDTH-1:0] load_extract(
        input logic [MEMWIDTH-1:0] word,
        input logic [1:0]          size,
        input logic [1:0]          lane,
        input logic                uns
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_extract = uns ? {{(MEMWIDTH-8){1'b0}}, byte_v}
                                        : {{(MEMWIDTH-8){byte_v[7]}}, byte_v};
            2'b01:   load_extract = uns ? {{(MEMWIDTH-16){1'b0}}, half_v}
                                        : {{(MEMWIDTH-16){half_v[15]}}, half_v};
            default: load_extract = word;
        endcase
    endfunction

    // Replace only the addressed lane(s) of the old word with the low bits of the store data.
    function automatic logic [MEMWIDTH-1:0] store_merge(
        input logic [MEMWIDTH-1:0] word,
        input logic [MEMWIDTH-1:0] wdata,
        input logic [1:0]          size,
        input logic [1:0]          lane
    );
        store_merge = word;
        case (size)
            2'b00:   store_merge[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   store_merge[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_merge = wdata;
        endcase
    endfunction

    assign accept_s     = ReqValid && (state_r == IDLE);
    assign misaligned_s = is_misaligned(ReqSize, ReqAddr[1:0]);
    assign word_store_s = ReqWrite && ReqSize[1];

    assign ReqReady     = (state_r == IDLE);
    assign MemoryRead   = (state_r == READ);
    assign MemoryWrite  = (state_r == WRITE);
    assign RspValid     = rsp_valid_r;
    assign RspData      = rsp_data_r;
    assign RspError     = rsp_error_r;
    assign MemAddress   = mem_address_r;
    assign MemWriteData = mem_write_data_r;

    // State register; reset abandons any in-flight request.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode: word stores go straight to WRITE, everything else reads first.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !misaligned_s) begin
                    if (word_store_s) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = READ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ:    state_next_s = DATA;
            DATA: begin
                if (req_write_r) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Request capture, memory address/data registers and the response registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            req_write_r      <= 1'b0;
            req_size_r       <= 2'b00;
            req_unsigned_r   <= 1'b0;
            req_lane_r       <= 2'b00;
            req_wdata_r      <= {MEMWIDTH{1'b0}};
            rsp_valid_r      <= 1'b0;
            rsp_data_r       <= {MEMWIDTH{1'b0}};
            rsp_error_r      <= 1'b0;
            mem_address_r    <= {ADDSIZE{1'b0}};
            mem_write_data_r <= {MEMWIDTH{1'b0}};
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (misaligned_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_error_r <= 1'b1;
                            rsp_data_r  <= {MEMWIDTH{1'b0}};
                        end else begin
                            req_write_r    <= ReqWrite;
                            req_size_r     <= ReqSize;
                            req_unsigned_r <= ReqUnsigned;
                            req_lane_r     <= ReqAddr[1:0];
                            req_wdata_r    <= ReqWData;
                            mem_address_r  <= ReqAddr[ADDSIZE+1:2];
                            if (word_store_s) begin
                                mem_write_data_r <= ReqWData;
                            end
                        end
                    end
                end
                DATA: begin
                    if (req_write_r) begin
                        mem_write_data_r <= store_merge(MemReadData, req_wdata_r,
                                                        req_size_r, req_lane_r);
                    end else begin
                        rsp_valid_r <= 1'b1;
                        rsp_error_r <= 1'b0;
                        rsp_data_r  <= load_extract(MemReadData, req_size_r,
                                                    req_lane_r, req_unsigned_r);
                    end
                end
                WRITE: begin
                    rsp_valid_r <= 1'b1;
                    rsp_error_r <= 1'b0;
                    rsp_data_r  <= {MEMWIDTH{1'b0}};
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
